// File: rtl/exec_pkg.sv
// Opcode, class, latency and control tables for the SPU execute issue stage,
// plus the decode function and the scoreboard slot type.
package exec_pkg;

  localparam int RT_W  = 7;
  localparam int LAT_W = 3;

  localparam int LAT_FX = 2;
  localparam int LAT_SH = 4;
  localparam int LAT_FP = 6;

  typedef enum logic [1:0] {
    CLS_FX  = 2'd0,
    CLS_SH  = 2'd1,
    CLS_FP  = 2'd2,
    CLS_ILL = 2'd3
  } cls_e;

  localparam logic [10:0] OP_AH   = 11'b00011001000;
  localparam logic [10:0] OP_A    = 11'b00011000000;
  localparam logic [10:0] OP_SF   = 11'b00001000000;
  localparam logic [10:0] OP_AND  = 11'b00011000001;
  localparam logic [10:0] OP_OR   = 11'b00001000001;
  localparam logic [10:0] OP_XOR  = 11'b01001000001;
  localparam logic [10:0] OP_SHLH = 11'b00001011111;
  localparam logic [10:0] OP_ROT  = 11'b00001011000;
  localparam logic [10:0] OP_FA   = 11'b01011000100;
  localparam logic [10:0] OP_FM   = 11'b01011000110;

  localparam logic [3:0] CTL_AH   = 4'b0001;
  localparam logic [3:0] CTL_A    = 4'b0000;
  localparam logic [3:0] CTL_SF   = 4'b0010;
  localparam logic [3:0] CTL_AND  = 4'b0100;
  localparam logic [3:0] CTL_OR   = 4'b0101;
  localparam logic [3:0] CTL_XOR  = 4'b0110;
  localparam logic [3:0] CTL_SHLH = 4'b1000;
  localparam logic [3:0] CTL_ROT  = 4'b1001;
  localparam logic [3:0] CTL_FA   = 4'b1100;
  localparam logic [3:0] CTL_FM   = 4'b1101;
  localparam logic [3:0] CTL_NOP  = 4'b1111;

  typedef struct packed {
    cls_e             cls;
    logic [3:0]       ctrl;
    logic [LAT_W-1:0] lat;
  } dec_t;

  typedef struct packed {
    logic            v;
    logic [RT_W-1:0] rt;
  } slot_t;

  function automatic dec_t decode_op(input logic [10:0] op);
    dec_t d;
    d.cls  = CLS_ILL;
    d.ctrl = CTL_NOP;
    d.lat  = '0;
    case (op)
      OP_AH:   begin d.cls = CLS_FX; d.ctrl = CTL_AH;   end
      OP_A:    begin d.cls = CLS_FX; d.ctrl = CTL_A;    end
      OP_SF:   begin d.cls = CLS_FX; d.ctrl = CTL_SF;   end
      OP_AND:  begin d.cls = CLS_FX; d.ctrl = CTL_AND;  end
      OP_OR:   begin d.cls = CLS_FX; d.ctrl = CTL_OR;   end
      OP_XOR:  begin d.cls = CLS_FX; d.ctrl = CTL_XOR;  end
      OP_SHLH: begin d.cls = CLS_SH; d.ctrl = CTL_SHLH; end
      OP_ROT:  begin d.cls = CLS_SH; d.ctrl = CTL_ROT;  end
      OP_FA:   begin d.cls = CLS_FP; d.ctrl = CTL_FA;   end
      OP_FM:   begin d.cls = CLS_FP; d.ctrl = CTL_FM;   end
      default: ;
    endcase
    case (d.cls)
      CLS_FX:  d.lat = 3'(LAT_FX);
      CLS_SH:  d.lat = 3'(LAT_SH);
      CLS_FP:  d.lat = 3'(LAT_FP);
      default: d.lat = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/exec_scoreboard.sv
// Latency-slot scoreboard: slot k holds the result retiring k cycles from now.
// Slot 0 drives writeback; match vectors over slots 1.. feed the issue stall.
module exec_scoreboard
  import exec_pkg::*;
#(
  parameter int MAX_LAT = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_ins_vld,
  input  logic [LAT_W-1:0] i_ins_lat,
  input  logic [RT_W-1:0]  i_ins_rt,
  input  logic [RT_W-1:0]  i_ra,
  input  logic [RT_W-1:0]  i_rb,
  input  logic [RT_W-1:0]  i_rc,
  input  logic             i_ra_used,
  input  logic             i_rb_used,
  input  logic             i_rc_used,
  output logic             o_raw,
  output logic             o_waw,
  output logic             o_wbc,
  output logic             o_wb_vld,
  output logic [RT_W-1:0]  o_wb_rt
);

  slot_t r_p [MAX_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LAT; i++) r_p[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < MAX_LAT; i++) r_p[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_LAT - 1; i++) r_p[i] <= r_p[i+1];
      r_p[MAX_LAT-1] <= '0;
      // Insert lands in the post-shift image, so latency L occupies slot L-1.
      if (i_ins_vld && i_ins_lat != '0) r_p[i_ins_lat - 1'b1] <= {1'b1, i_ins_rt};
    end
  end

  // Slot 0 is retiring and the register file writes through, so it never stalls.
  always_comb begin
    o_raw = 1'b0;
    o_waw = 1'b0;
    o_wbc = 1'b0;
    for (int i = 1; i < MAX_LAT; i++) begin
      if (r_p[i].v) begin
        if ((i_ra_used && i_ra == r_p[i].rt) ||
            (i_rb_used && i_rb == r_p[i].rt) ||
            (i_rc_used && i_rc == r_p[i].rt)) o_raw = 1'b1;
        if (i_ins_rt == r_p[i].rt) o_waw = 1'b1;
        if (int'(i_ins_lat) == i) o_wbc = 1'b1;
      end
    end
  end

  assign o_wb_vld = r_p[0].v;
  assign o_wb_rt  = r_p[0].rt;

endmodule

// File: rtl/exec_issue_ctrl.sv
// SPU execute issue control: decode, hazard/collision stall, registered issue (1 cycle).
// in_ready is combinational; writeback presents at most one result per cycle.
module exec_issue_ctrl
  import exec_pkg::*;
#(
  parameter int MAX_LAT = 7,
  parameter int REG_AW  = RT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [10:0]       in_opcode,
  input  logic [REG_AW-1:0] in_ra,
  input  logic [REG_AW-1:0] in_rb,
  input  logic [REG_AW-1:0] in_rc,
  input  logic              in_ra_used,
  input  logic              in_rb_used,
  input  logic              in_rc_used,
  input  logic [REG_AW-1:0] in_rt,
  input  logic              flush,
  output logic              issue_valid,
  output logic [10:0]       issue_opcode,
  output logic [REG_AW-1:0] issue_ra,
  output logic [REG_AW-1:0] issue_rb,
  output logic [REG_AW-1:0] issue_rc,
  output logic [REG_AW-1:0] issue_rt,
  output logic [3:0]        control_EX,
  output logic              illegal_op,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rt
);

  dec_t w_dec;
  logic w_ill, w_raw, w_waw, w_wbc, w_issue;

  logic              r_issue_vld, r_ill;
  logic [10:0]       r_opcode;
  logic [REG_AW-1:0] r_ra, r_rb, r_rc, r_rt;
  logic [3:0]        r_ctrl;

  assign w_dec = decode_op(in_opcode);
  assign w_ill = (w_dec.cls == CLS_ILL);

  // Illegal ops never write back, so only RAW can hold them.
  assign in_ready = !flush && !w_raw && (w_ill || (!w_waw && !w_wbc));
  assign w_issue  = in_valid && in_ready;

  exec_scoreboard #(.MAX_LAT(MAX_LAT)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (flush),
    .i_ins_vld (w_issue && !w_ill),
    .i_ins_lat (w_dec.lat),
    .i_ins_rt  (in_rt),
    .i_ra      (in_ra),
    .i_rb      (in_rb),
    .i_rc      (in_rc),
    .i_ra_used (in_ra_used),
    .i_rb_used (in_rb_used),
    .i_rc_used (in_rc_used),
    .o_raw     (w_raw),
    .o_waw     (w_waw),
    .o_wbc     (w_wbc),
    .o_wb_vld  (wb_valid),
    .o_wb_rt   (wb_rt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_vld <= 1'b0;
      r_ill       <= 1'b0;
      r_opcode    <= '0;
      r_ra        <= '0;
      r_rb        <= '0;
      r_rc        <= '0;
      r_rt        <= '0;
      r_ctrl      <= '0;
    end else begin
      r_issue_vld <= w_issue;
      r_ill       <= w_issue && w_ill;
      if (w_issue) begin
        r_opcode <= in_opcode;
        r_ra     <= in_ra;
        r_rb     <= in_rb;
        r_rc     <= in_rc;
        r_rt     <= in_rt;
        r_ctrl   <= w_dec.ctrl;
      end
    end
  end

  assign issue_valid  = r_issue_vld;
  assign illegal_op   = r_ill;
  assign issue_opcode = r_opcode;
  assign issue_ra     = r_ra;
  assign issue_rb     = r_rb;
  assign issue_rc     = r_rc;
  assign issue_rt     = r_rt;
  assign control_EX   = r_ctrl;

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Bench for exec_issue_ctrl: directed scenarios plus a randomized run against
// a retire-cycle list model of in-flight results.
module tb_exec_issue_ctrl;

  localparam int TB_MAX_LAT = 7;

  localparam logic [10:0] T_AH   = 11'b00011001000;
  localparam logic [10:0] T_A    = 11'b00011000000;
  localparam logic [10:0] T_SHLH = 11'b00001011111;
  localparam logic [10:0] T_FA   = 11'b01011000100;
  localparam logic [10:0] T_FM   = 11'b01011000110;
  localparam logic [10:0] T_BAD  = 11'b11111111111;

  logic [10:0] op_tab  [10] = '{11'b00011001000, 11'b00011000000, 11'b00001000000,
                                11'b00011000001, 11'b00001000001, 11'b01001000001,
                                11'b00001011111, 11'b00001011000, 11'b01011000100,
                                11'b01011000110};
  int          lat_tab [10] = '{2, 2, 2, 2, 2, 2, 4, 4, 6, 6};
  logic [3:0]  ctl_tab [10] = '{4'b0001, 4'b0000, 4'b0010, 4'b0100, 4'b0101,
                                4'b0110, 4'b1000, 4'b1001, 4'b1100, 4'b1101};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, in_ra_used, in_rb_used, in_rc_used, flush;
  logic [10:0] in_opcode, issue_opcode;
  logic [6:0]  in_ra, in_rb, in_rc, in_rt;
  logic        issue_valid, illegal_op, wb_valid;
  logic [6:0]  issue_ra, issue_rb, issue_rc, issue_rt, wb_rt;
  logic [3:0]  control_EX;

  int n_checks = 0;
  int n_pass   = 0;
  int acc, stall;
  int wb_cyc[$];
  logic [6:0] wb_rtq[$];

  exec_issue_ctrl #(.MAX_LAT(TB_MAX_LAT), .REG_AW(7)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc),
    .in_ra_used(in_ra_used), .in_rb_used(in_rb_used), .in_rc_used(in_rc_used),
    .in_rt(in_rt), .flush(flush), .issue_valid(issue_valid),
    .issue_opcode(issue_opcode), .issue_ra(issue_ra), .issue_rb(issue_rb),
    .issue_rc(issue_rc), .issue_rt(issue_rt), .control_EX(control_EX),
    .illegal_op(illegal_op), .wb_valid(wb_valid), .wb_rt(wb_rt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [10:0] op, input logic [6:0] rt,
                       input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc,
                       input logic [2:0] used, input logic fl);
    in_valid = v; in_opcode = op; in_rt = rt;
    in_ra = ra; in_rb = rb; in_rc = rc;
    {in_ra_used, in_rb_used, in_rc_used} = used;
    flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 11'd0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
  endtask

  function automatic void mdec(input logic [10:0] op, output bit ill, output int lat,
                               output logic [3:0] ctl);
    ill = 1'b1; lat = 0; ctl = 4'b1111;
    for (int k = 0; k < 10; k++)
      if (op_tab[k] == op) begin ill = 1'b0; lat = lat_tab[k]; ctl = ctl_tab[k]; end
  endfunction

  // First op issues at cycle 0 into an empty pipe; second op is held from cycle t2 until accepted.
  task automatic run_pair(input logic [10:0] op1, input logic [6:0] rt1,
                          input logic [10:0] op2, input logic [6:0] rt2, input logic [6:0] ra2,
                          input logic [2:0] used2, input int t2, input int fl_cyc, input int ncyc);
    bit pend2;
    pend2 = 1'b0; acc = -1; stall = 0;
    wb_cyc.delete(); wb_rtq.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (c == t2) pend2 = 1'b1;
      if (pend2) drive(1'b1, op2, rt2, ra2, 7'd99, 7'd98, used2, c == fl_cyc);
      else if (c == 0) drive(1'b1, op1, rt1, 7'd100, 7'd101, 7'd102, 3'b000, 1'b0);
      else drive(1'b0, 11'd0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, c == fl_cyc);
      @(negedge clk);
      if (wb_valid) begin wb_cyc.push_back(c); wb_rtq.push_back(wb_rt); end
      if (pend2 && in_ready) acc = c;
      if (pend2 && !in_ready) stall++;
      @(posedge clk); #1;
      if (acc == c) pend2 = 1'b0;
    end
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL rst_issue_valid got %b want 0", issue_valid); else n_pass++;
    n_checks++; if (illegal_op !== 1'b0) $display("FAIL rst_illegal_op got %b want 0", illegal_op); else n_pass++;
    n_checks++; if (wb_valid !== 1'b0) $display("FAIL rst_wb_valid got %b want 0", wb_valid); else n_pass++;
    n_checks++; if ({issue_opcode, issue_ra, issue_rb, issue_rc, issue_rt, control_EX, wb_rt} !== '0)
      $display("FAIL rst_outputs got %h want 0", {issue_opcode, issue_ra, issue_rb, issue_rc, issue_rt, control_EX, wb_rt}); else n_pass++;
    flush = 1'b1; #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_flush_ready got %b want 0", in_ready); else n_pass++;
    flush = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fx_issue();
    drive(1'b1, T_AH, 7'd5, 7'd1, 7'd2, 7'd0, 3'b110, 1'b0);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL fx_ready got %b want 1", in_ready); else n_pass++;
    @(posedge clk); #1;
    idle();
    n_checks++; if (issue_valid !== 1'b1) $display("FAIL fx_issue_valid got %b want 1", issue_valid); else n_pass++;
    n_checks++; if (control_EX !== 4'b0001) $display("FAIL fx_control got %b want 0001", control_EX); else n_pass++;
    n_checks++; if ({issue_opcode, issue_rt, issue_ra, issue_rb} !== {T_AH, 7'd5, 7'd1, 7'd2})
      $display("FAIL fx_operands got %h want %h", {issue_opcode, issue_rt, issue_ra, issue_rb}, {T_AH, 7'd5, 7'd1, 7'd2}); else n_pass++;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_checks++; if (wb_valid !== (c == 2)) $display("FAIL fx_wb_valid c%0d got %b want %b", c, wb_valid, c == 2); else n_pass++;
      if (c == 2) begin
        n_checks++; if (wb_rt !== 7'd5) $display("FAIL fx_wb_rt got %0d want 5", wb_rt); else n_pass++;
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL fx_issue_pulse got %b want 0", issue_valid); else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 10; c++) begin
      if (c < 6) drive(1'b1, T_AH, 7'(40 + c), 7'd60, 7'd61, 7'd0, 3'b110, 1'b0); else idle();
      @(negedge clk);
      if (c < 6) begin
        n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready c%0d got %b want 1", c, in_ready); else n_pass++;
      end
      if (c >= 2 && c < 8) begin
        n_checks++; if ({wb_valid, wb_rt} !== {1'b1, 7'(40 + c - 2)})
          $display("FAIL b2b_wb c%0d got %b/%0d want 1/%0d", c, wb_valid, wb_rt, 40 + c - 2); else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_raw();
    run_pair(T_FA, 7'd10, T_A, 7'd11, 7'd10, 3'b110, 1, -1, 12);
    n_checks++; if (acc !== 6) $display("FAIL raw_accept got %0d want 6", acc); else n_pass++;
    n_checks++; if (stall !== 5) $display("FAIL raw_stall got %0d want 5", stall); else n_pass++;
    n_checks++; if (wb_cyc.size() !== 2) $display("FAIL raw_wb_count got %0d want 2", wb_cyc.size()); else n_pass++;
    if (wb_cyc.size() == 2) begin
      n_checks++; if ({wb_cyc[0], wb_rtq[0], wb_cyc[1], wb_rtq[1]} !== {32'd6, 7'd10, 32'd8, 7'd11})
        $display("FAIL raw_wb got c%0d/r%0d c%0d/r%0d want c6/r10 c8/r11", wb_cyc[0], wb_rtq[0], wb_cyc[1], wb_rtq[1]); else n_pass++;
    end
  endtask

  task automatic test_waw();
    run_pair(T_FM, 7'd3, T_AH, 7'd3, 7'd50, 3'b100, 4, -1, 12);
    n_checks++; if (acc !== 6) $display("FAIL waw_accept got %0d want 6", acc); else n_pass++;
    n_checks++; if (stall !== 2) $display("FAIL waw_stall got %0d want 2", stall); else n_pass++;
    n_checks++; if (wb_cyc.size() !== 2) $display("FAIL waw_wb_count got %0d want 2", wb_cyc.size()); else n_pass++;
    if (wb_cyc.size() == 2) begin
      n_checks++; if ({wb_cyc[0], wb_rtq[0], wb_cyc[1], wb_rtq[1]} !== {32'd6, 7'd3, 32'd8, 7'd3})
        $display("FAIL waw_wb got c%0d/r%0d c%0d/r%0d want c6/r3 c8/r3", wb_cyc[0], wb_rtq[0], wb_cyc[1], wb_rtq[1]); else n_pass++;
    end
  endtask

  task automatic test_wb_collision();
    run_pair(T_FA, 7'd20, T_SHLH, 7'd21, 7'd0, 3'b000, 2, -1, 10);
    n_checks++; if (acc !== 3) $display("FAIL wbc_accept got %0d want 3", acc); else n_pass++;
    n_checks++; if (stall !== 1) $display("FAIL wbc_stall got %0d want 1", stall); else n_pass++;
    n_checks++; if (wb_cyc.size() !== 2) $display("FAIL wbc_wb_count got %0d want 2", wb_cyc.size()); else n_pass++;
    if (wb_cyc.size() == 2) begin
      n_checks++; if ({wb_cyc[0], wb_rtq[0], wb_cyc[1], wb_rtq[1]} !== {32'd6, 7'd20, 32'd7, 7'd21})
        $display("FAIL wbc_wb got c%0d/r%0d c%0d/r%0d want c6/r20 c7/r21", wb_cyc[0], wb_rtq[0], wb_cyc[1], wb_rtq[1]); else n_pass++;
    end
  endtask

  task automatic test_flush();
    run_pair(T_FA, 7'd9, T_A, 7'd12, 7'd9, 3'b100, 2, 2, 10);
    n_checks++; if (acc !== 3) $display("FAIL flush_accept got %0d want 3", acc); else n_pass++;
    n_checks++; if (stall !== 1) $display("FAIL flush_stall got %0d want 1", stall); else n_pass++;
    n_checks++; if (wb_cyc.size() !== 1) $display("FAIL flush_wb_count got %0d want 1", wb_cyc.size()); else n_pass++;
    if (wb_cyc.size() == 1) begin
      n_checks++; if ({wb_cyc[0], wb_rtq[0]} !== {32'd5, 7'd12})
        $display("FAIL flush_wb got c%0d/r%0d want c5/r12", wb_cyc[0], wb_rtq[0]); else n_pass++;
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, T_BAD, 7'd30, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL ill_ready got %b want 1", in_ready); else n_pass++;
    @(posedge clk); #1;
    idle();
    n_checks++; if ({issue_valid, illegal_op, control_EX} !== {1'b1, 1'b1, 4'b1111})
      $display("FAIL ill_issue got %b/%b/%b want 1/1/1111", issue_valid, illegal_op, control_EX); else n_pass++;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      n_checks++; if (wb_valid !== 1'b0) $display("FAIL ill_wb c%0d got %b want 0", c, wb_valid); else n_pass++;
      if (c == 2) begin
        n_checks++; if (illegal_op !== 1'b0) $display("FAIL ill_pulse got %b want 0", illegal_op); else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, T_FM, 7'd40, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
    @(posedge clk); #1;
    idle();
    n_checks++; if (issue_valid !== 1'b1) $display("FAIL arst_pre_issue got %b want 1", issue_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({issue_valid, illegal_op, wb_valid} !== 3'b000)
      $display("FAIL arst_flags got %b want 000", {issue_valid, illegal_op, wb_valid}); else n_pass++;
    n_checks++; if ({issue_opcode, issue_ra, issue_rb, issue_rc, issue_rt, control_EX, wb_rt} !== '0)
      $display("FAIL arst_outputs got %h want 0", {issue_opcode, issue_ra, issue_rb, issue_rc, issue_rt, control_EX, wb_rt}); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++; if (wb_valid !== 1'b0) $display("FAIL arst_stale_wb c%0d got %b want 0", c, wb_valid); else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int ncyc);
    int ret_q[$];
    logic [6:0] rtq[$];
    logic [10:0] op;
    logic [6:0] rt, ra, rb, rc;
    logic [2:0] used;
    bit v, fl, ill, raw, waw, wbc, ewb, iss;
    logic [6:0] ewb_rt;
    logic [3:0] ctl;
    int lat, k, d;
    for (int t = 0; t < ncyc; t++) begin
      v = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, 10);
      op = (k == 10) ? 11'($urandom) : op_tab[k];
      rt = 7'($urandom_range(0, 7)); ra = 7'($urandom_range(0, 7));
      rb = 7'($urandom_range(0, 7)); rc = 7'($urandom_range(0, 7));
      used = 3'($urandom_range(0, 7));
      fl = ($urandom_range(0, 19) == 0);
      drive(v, op, rt, ra, rb, rc, used, fl);
      mdec(op, ill, lat, ctl);
      raw = 1'b0; waw = 1'b0; wbc = 1'b0; ewb = 1'b0; ewb_rt = '0;
      foreach (ret_q[j]) begin
        d = ret_q[j] - t;
        if (d == 0) begin ewb = 1'b1; ewb_rt = rtq[j]; end
        if (d >= 1) begin
          if ((used[2] && ra == rtq[j]) || (used[1] && rb == rtq[j]) || (used[0] && rc == rtq[j])) raw = 1'b1;
          if (rt == rtq[j]) waw = 1'b1;
          if (!ill && lat < TB_MAX_LAT && d == lat) wbc = 1'b1;
        end
      end
      iss = v && !fl && !raw && (ill || (!waw && !wbc));
      @(negedge clk);
      n_checks++; if (in_ready !== (!fl && !raw && (ill || (!waw && !wbc))))
        $display("FAIL rnd_ready t%0d got %b want %b", t, in_ready, !fl && !raw && (ill || (!waw && !wbc))); else n_pass++;
      n_checks++; if (wb_valid !== ewb) $display("FAIL rnd_wb_valid t%0d got %b want %b", t, wb_valid, ewb); else n_pass++;
      if (ewb) begin
        n_checks++; if (wb_rt !== ewb_rt) $display("FAIL rnd_wb_rt t%0d got %0d want %0d", t, wb_rt, ewb_rt); else n_pass++;
      end
      @(posedge clk); #1;
      if (fl) begin
        ret_q.delete(); rtq.delete();
      end else begin
        for (int j = ret_q.size() - 1; j >= 0; j--)
          if (ret_q[j] <= t) begin ret_q.delete(j); rtq.delete(j); end
      end
      if (iss && !ill) begin ret_q.push_back(t + lat); rtq.push_back(rt); end
      n_checks++; if ({issue_valid, illegal_op} !== {iss, iss && ill})
        $display("FAIL rnd_issue t%0d got %b%b want %b%b", t, issue_valid, illegal_op, iss, iss && ill); else n_pass++;
      if (iss) begin
        n_checks++; if ({control_EX, issue_opcode, issue_rt, issue_ra} !== {ctl, op, rt, ra})
          $display("FAIL rnd_operands t%0d got %h want %h", t, {control_EX, issue_opcode, issue_rt, issue_ra}, {ctl, op, rt, ra}); else n_pass++;
      end
    end
    idle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fx_issue();
    test_back_to_back();
    test_raw();
    test_waw();
    test_wb_collision();
    test_flush();
    test_illegal();
    test_async_reset();
    test_random(600);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
